hdmi_vpg_param: RTL and testbench



---
 rtl/hdmi_vpg_param.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_hdmi_vpg_param.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_vpg_param.sv
`default_nettype none
// ============================================================================
// Module   : hdmi_vpg_param
// Purpose  : Parametrised HDMI video pattern generator. Produces programmable
//            DE/HS/VS timing and one of four test patterns on a parallel RGB
//            bus in the pixel-clock domain. Pattern changes take effect only
//            at the frame origin (h=0, v=0), so a frame is never torn.
// Ports    : clk         - pixel clock
//            reset       - asynchronous, active-high reset
//            mode[1:0]   - 0 colour bars, 1 gradient, 2 grid, 3 moving box
//            de          - data enable, high during the active region
//            hs / vs     - syncs at HS_POL / VS_POL active level
//            vga_r/g/b   - pixel colour, COLOR_W bits per channel
//            frame_start - one-cycle pulse coincident with pixel (0,0)
// Config   : define VPG_MOVING_BOX_EN to build the bouncing red box for
//            mode 3; otherwise mode 3 is a flat mid-grey field and the box
//            position registers are not built.
// Revision : 1.0 - initial release
// ============================================================================
module hdmi_vpg_param #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int COLOR_W  = 8,
    parameter int GRID     = 32,
    parameter int BOX      = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         mode,
    output logic               de,
    output logic               hs,
    output logic               vs,
    output logic [COLOR_W-1:0] vga_r,
    output logic [COLOR_W-1:0] vga_g,
    output logic [COLOR_W-1:0] vga_b,
    output logic               frame_start
);

    localparam int c_h_total = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_v_total = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int c_hw      = $clog2(c_h_total);
    localparam int c_vw      = $clog2(c_v_total);

    localparam logic [c_hw-1:0] c_h_one  = c_hw'(1);
    localparam logic [c_vw-1:0] c_v_one  = c_vw'(1);
    localparam logic [c_hw-1:0] c_h_last = c_hw'(c_h_total - 1);
    localparam logic [c_vw-1:0] c_v_last = c_vw'(c_v_total - 1);
    localparam logic [c_hw-1:0] c_h_act  = c_hw'(H_ACTIVE);
    localparam logic [c_vw-1:0] c_v_act  = c_vw'(V_ACTIVE);
    localparam logic [c_hw-1:0] c_h_edge = c_hw'(H_ACTIVE - 1);
    localparam logic [c_vw-1:0] c_v_edge = c_vw'(V_ACTIVE - 1);

    // Sync window bounds carry one extra bit so an end bound equal to the
    // total count cannot alias back to zero.
    localparam logic [c_hw:0] c_hs_beg = (c_hw+1)'(H_ACTIVE + H_FP);
    localparam logic [c_hw:0] c_hs_end = (c_hw+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [c_vw:0] c_vs_beg = (c_vw+1)'(V_ACTIVE + V_FP);
    localparam logic [c_vw:0] c_vs_end = (c_vw+1)'(V_ACTIVE + V_FP + V_SYNC);

    // Bar width never drops below one pixel for very narrow rasters.
    localparam int              c_bar_w_int = (H_ACTIVE >= 8) ? (H_ACTIVE / 8) : 1;
    localparam logic [c_hw-1:0] c_bar_w     = c_hw'(c_bar_w_int);
    localparam logic [c_hw-1:0] c_bar_last  = c_hw'(7);

    // GRID is a power of two, so "mod GRID == 0" is a mask test.
    localparam logic [c_hw-1:0] c_grid_hmask = c_hw'(GRID - 1);
    localparam logic [c_vw-1:0] c_grid_vmask = c_vw'(GRID - 1);

    localparam logic [COLOR_W-1:0] c_ones = '1;
    localparam logic [COLOR_W-1:0] c_zero = '0;
    localparam logic [COLOR_W-1:0] c_grey = {1'b1, {(COLOR_W-1){1'b0}}};

    localparam logic [1:0] c_mode_bars = 2'd0;
    localparam logic [1:0] c_mode_grad = 2'd1;
    localparam logic [1:0] c_mode_grid = 2'd2;

    // ------------------------------------------------------------------
    // Raster counters
    // ------------------------------------------------------------------
    logic [c_hw-1:0] r_h;
    logic [c_vw-1:0] r_v;
    logic            w_h_wrap;
    logic            w_v_wrap;

    assign w_h_wrap = (r_h == c_h_last);
    assign w_v_wrap = (r_v == c_v_last);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_h <= '0;
            r_v <= '0;
        end else begin
            r_h <= w_h_wrap ? '0 : (r_h + c_h_one);
            if (w_h_wrap) begin
                r_v <= w_v_wrap ? '0 : (r_v + c_v_one);
            end
        end
    end

    // ------------------------------------------------------------------
    // Mode capture: at the origin the live input is used directly, so a
    // change landing exactly on (0,0) already drives that first pixel.
    // ------------------------------------------------------------------
    logic [1:0] r_mode_q;
    logic [1:0] w_mode;
    logic       w_origin;

    assign w_origin = (r_h == '0) && (r_v == '0);
    assign w_mode   = w_origin ? mode : r_mode_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mode_q <= 2'd0;
        end else if (w_origin) begin
            r_mode_q <= mode;
        end
    end

    // ------------------------------------------------------------------
    // Timing decode
    // ------------------------------------------------------------------
    logic w_active;
    logic w_hs_act;
    logic w_vs_act;

    assign w_active = (r_h < c_h_act) && (r_v < c_v_act);
    assign w_hs_act = ({1'b0, r_h} >= c_hs_beg) && ({1'b0, r_h} < c_hs_end);
    assign w_vs_act = ({1'b0, r_v} >= c_vs_beg) && ({1'b0, r_v} < c_vs_end);

    // ------------------------------------------------------------------
    // Pattern sources
    // ------------------------------------------------------------------
    logic [c_hw-1:0]    w_bar_q;
    logic [2:0]         w_bar_idx;
    logic [COLOR_W-1:0] w_gh;
    logic [COLOR_W-1:0] w_gv;
    logic               w_grid_on;

    assign w_bar_q   = r_h / c_bar_w;
    assign w_bar_idx = (w_bar_q > c_bar_last) ? 3'd7 : w_bar_q[2:0];

    // Casting to COLOR_W truncates or zero-extends, giving mod 2^COLOR_W.
    assign w_gh = COLOR_W'(r_h);
    assign w_gv = COLOR_W'(r_v);

    assign w_grid_on = ((r_h & c_grid_hmask) == '0) || ((r_v & c_grid_vmask) == '0)
                     || (r_h == c_h_edge) || (r_v == c_v_edge);

`ifdef VPG_MOVING_BOX_EN
    localparam logic [c_hw-1:0] c_bx_max = c_hw'(H_ACTIVE - BOX);
    localparam logic [c_vw-1:0] c_by_max = c_vw'(V_ACTIVE - BOX);
    localparam logic [c_hw-1:0] c_box_h  = c_hw'(BOX);
    localparam logic [c_vw-1:0] c_box_v  = c_vw'(BOX);

    logic [c_hw-1:0] r_bx;
    logic [c_vw-1:0] r_by;
    logic            r_bx_dn;      // 1 = moving towards 0
    logic            r_by_dn;
    logic [c_hw-1:0] w_bx_next;
    logic [c_vw-1:0] w_by_next;
    logic            w_box_upd;
    logic            w_box_in;

    // Update on the first blanking line so the new position is stable
    // before the next active region starts.
    assign w_box_upd = (r_h == '0) && (r_v == c_v_act);
    assign w_bx_next = r_bx_dn ? (r_bx - c_h_one) : (r_bx + c_h_one);
    assign w_by_next = r_by_dn ? (r_by - c_v_one) : (r_by + c_v_one);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bx    <= '0;
            r_by    <= '0;
            r_bx_dn <= 1'b0;
            r_by_dn <= 1'b0;
        end else if (w_box_upd) begin
            r_bx <= w_bx_next;
            r_by <= w_by_next;
            // Reverse on arrival at an end stop so the next step bounces.
            if (w_bx_next == c_bx_max) begin
                r_bx_dn <= 1'b1;
            end else if (w_bx_next == '0) begin
                r_bx_dn <= 1'b0;
            end
            if (w_by_next == c_by_max) begin
                r_by_dn <= 1'b1;
            end else if (w_by_next == '0) begin
                r_by_dn <= 1'b0;
            end
        end
    end

    assign w_box_in = (r_h >= r_bx) && (r_h < (r_bx + c_box_h))
                   && (r_v >= r_by) && (r_v < (r_by + c_box_v));
`endif

    // ------------------------------------------------------------------
    // Pixel select
    // ------------------------------------------------------------------
    logic [COLOR_W-1:0] w_r;
    logic [COLOR_W-1:0] w_g;
    logic [COLOR_W-1:0] w_b;

    always_comb begin
        w_r = c_zero;
        w_g = c_zero;
        w_b = c_zero;
        if (w_active) begin
            case (w_mode)
                c_mode_bars: begin
                    // Bar order white..black maps onto inverted index bits.
                    w_r = {COLOR_W{~w_bar_idx[1]}};
                    w_g = {COLOR_W{~w_bar_idx[2]}};
                    w_b = {COLOR_W{~w_bar_idx[0]}};
                end
                c_mode_grad: begin
                    w_r = w_gh;
                    w_g = w_gv;
                    w_b = w_gh + w_gv;
                end
                c_mode_grid: begin
                    w_r = w_grid_on ? c_ones : c_zero;
                    w_g = w_grid_on ? c_ones : c_zero;
                    w_b = w_grid_on ? c_ones : c_zero;
                end
                default: begin
`ifdef VPG_MOVING_BOX_EN
                    w_r = w_box_in ? c_ones : c_grey;
                    w_g = w_box_in ? c_zero : c_grey;
                    w_b = w_box_in ? c_zero : c_grey;
`else
                    w_r = c_grey;
                    w_g = c_grey;
                    w_b = c_grey;
`endif
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output registers: one clock behind the counters, all aligned.
    // ------------------------------------------------------------------
    logic               r_de;
    logic               r_hs;
    logic               r_vs;
    logic               r_fs;
    logic [COLOR_W-1:0] r_r;
    logic [COLOR_W-1:0] r_g;
    logic [COLOR_W-1:0] r_b;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_de <= 1'b0;
            r_hs <= ~HS_POL;
            r_vs <= ~VS_POL;
            r_fs <= 1'b0;
            r_r  <= c_zero;
            r_g  <= c_zero;
            r_b  <= c_zero;
        end else begin
            r_de <= w_active;
            r_hs <= w_hs_act ? HS_POL : ~HS_POL;
            r_vs <= w_vs_act ? VS_POL : ~VS_POL;
            r_fs <= w_origin;
            r_r  <= w_r;
            r_g  <= w_g;
            r_b  <= w_b;
        end
    end

    assign de          = r_de;
    assign hs          = r_hs;
    assign vs          = r_vs;
    assign frame_start = r_fs;
    assign vga_r       = r_r;
    assign vga_g       = r_g;
    assign vga_b       = r_b;

endmodule
`default_nettype wire

// File: tb/tb_hdmi_vpg_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_hdmi_vpg_param
// Purpose  : Self-checking bench for hdmi_vpg_param on a small 24x12 raster.
//            A reference raster model pushes the expected output of every
//            evaluated pixel into a queue; each scenario task pops and
//            compares after the clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hdmi_vpg_param;

    localparam int HA  = 16;
    localparam int HF  = 2;
    localparam int HSW = 3;
    localparam int HB  = 3;
    localparam int VA  = 8;
    localparam int VF  = 1;
    localparam int VSW = 2;
    localparam int VB  = 1;
    localparam int HT  = HA + HF + HSW + HB;
    localparam int VT  = VA + VF + VSW + VB;
    localparam int FR  = HT * VT;
    localparam int GRIDP = 4;
    localparam int BOXP  = 4;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] mode  = 2'd0;
    logic       de, hs, vs, frame_start;
    logic [7:0] vga_r, vga_g, vga_b;

    hdmi_vpg_param #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
        .HS_POL(1'b0), .VS_POL(1'b0),
        .COLOR_W(8), .GRID(GRIDP), .BOX(BOXP)
    ) dut (
        .clk(clk), .reset(reset), .mode(mode),
        .de(de), .hs(hs), .vs(vs),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         h;
        int         v;
        logic       de;
        logic       hs;
        logic       vs;
        logic       fs;
        logic [23:0] rgb;
    } exp_t;

    exp_t sb[$];
    int   m_h, m_v, m_mode_q, m_upd;
    int   checks   = 0;
    int   failures = 0;

    // Triangle wave: position after n one-pixel steps bouncing in [0,mx].
    function automatic int tri_pos(int n, int mx);
        int k;
        k = n % (2 * mx);
        return (k <= mx) ? k : (2 * mx - k);
    endfunction

    function automatic logic [23:0] model_rgb(int h, int v, int md, int n);
        int idx;
        int bx;
        int by;
        if (h >= HA || v >= VA) return 24'h000000;
        case (md)
            0: begin
                idx = h / (HA / 8);
                if (idx > 7) idx = 7;
                case (idx)
                    0: return 24'hFFFFFF;
                    1: return 24'hFFFF00;
                    2: return 24'h00FFFF;
                    3: return 24'h00FF00;
                    4: return 24'hFF00FF;
                    5: return 24'hFF0000;
                    6: return 24'h0000FF;
                    default: return 24'h000000;
                endcase
            end
            1: return {8'(h), 8'(v), 8'(h + v)};
            2: return ((h % GRIDP) == 0 || (v % GRIDP) == 0 || h == HA - 1 || v == VA - 1)
                      ? 24'hFFFFFF : 24'h000000;
            default: begin
`ifdef VPG_MOVING_BOX_EN
                bx = tri_pos(n, HA - BOXP);
                by = tri_pos(n, VA - BOXP);
                return (h >= bx && h < bx + BOXP && v >= by && v < by + BOXP)
                       ? 24'hFF0000 : 24'h808080;
`else
                bx = n;
                by = bx;
                return 24'h808080;
`endif
            end
        endcase
    endfunction

    task automatic model_reset();
        m_h = 0; m_v = 0; m_mode_q = 0; m_upd = 0;
        sb.delete();
    endtask

    // Predict the pixel evaluated at the next edge, then advance one clock.
    task automatic tick();
        exp_t e;
        int   md;
        md = (m_h == 0 && m_v == 0) ? int'(mode) : m_mode_q;
        if (m_h == 0 && m_v == 0) m_mode_q = md;
        e.h   = m_h;
        e.v   = m_v;
        e.de  = (m_h < HA && m_v < VA);
        e.hs  = !(m_h >= HA + HF && m_h < HA + HF + HSW);
        e.vs  = !(m_v >= VA + VF && m_v < VA + VF + VSW);
        e.fs  = (m_h == 0 && m_v == 0);
        e.rgb = model_rgb(m_h, m_v, md, m_upd);
        sb.push_back(e);
        if (m_h == 0 && m_v == VA) m_upd++;
        if (m_h == HT - 1) begin
            m_h = 0;
            m_v = (m_v == VT - 1) ? 0 : m_v + 1;
        end else begin
            m_h++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({de, hs, vs, frame_start, vga_r, vga_g, vga_b} !== {4'b0110, 24'h0}) begin
            failures++;
            $display("FAIL reset_state got=%h want=%h",
                     {de, hs, vs, frame_start, vga_r, vga_g, vga_b}, {4'b0110, 24'h0});
        end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        tick();
        e = sb.pop_front();
        checks++;
        if (frame_start !== 1'b1 || de !== 1'b1) begin
            failures++;
            $display("FAIL first_frame_start fs=%b de=%b want fs=1 de=1", frame_start, de);
        end
        checks++;
        if ({de, hs, vs, frame_start, vga_r, vga_g, vga_b} !== {e.de, e.hs, e.vs, e.fs, e.rgb}) begin
            failures++;
            $display("FAIL first_pixel got=%h want=%h",
                     {de, hs, vs, frame_start, vga_r, vga_g, vga_b}, {e.de, e.hs, e.vs, e.fs, e.rgb});
        end
    endtask

    task automatic test_timing();
        exp_t e;
        int   last_fs = -1;
        int   de_cnt  = 0;
        mode = 2'd0;
        for (int i = 0; i < 2 * FR; i++) begin
            tick();
            e = sb.pop_front();
            checks++;
            if ({de, hs, vs, frame_start} !== {e.de, e.hs, e.vs, e.fs}) begin
                failures++;
                $display("FAIL timing h=%0d v=%0d got de/hs/vs/fs=%b want=%b",
                         e.h, e.v, {de, hs, vs, frame_start}, {e.de, e.hs, e.vs, e.fs});
            end
            if (i < FR && de === 1'b1) de_cnt++;
            if (frame_start === 1'b1) begin
                if (last_fs >= 0) begin
                    checks++;
                    if (i - last_fs != FR) begin
                        failures++;
                        $display("FAIL frame_period got=%0d want=%0d", i - last_fs, FR);
                    end
                end
                last_fs = i;
            end
        end
        checks++;
        if (de_cnt != HA * VA) begin
            failures++;
            $display("FAIL de_per_frame got=%0d want=%0d", de_cnt, HA * VA);
        end
    endtask

    task automatic test_bars();
        exp_t e;
        mode = 2'd0;
        for (int i = 0; i < FR; i++) begin
            tick();
            e = sb.pop_front();
            checks++;
            if ({vga_r, vga_g, vga_b} !== e.rgb) begin
                failures++;
                $display("FAIL bars h=%0d v=%0d got=%h want=%h", e.h, e.v, {vga_r, vga_g, vga_b}, e.rgb);
            end
            if (de === 1'b0) begin
                checks++;
                if ({vga_r, vga_g, vga_b} !== 24'h0) begin
                    failures++;
                    $display("FAIL blank_rgb h=%0d v=%0d got=%h want=000000", e.h, e.v, {vga_r, vga_g, vga_b});
                end
            end
            if (e.v == 2 && (e.h == 0 || e.h == 10 || e.h == 15)) begin
                checks++;
                if ({vga_r, vga_g, vga_b} !== ((e.h == 0) ? 24'hFFFFFF : (e.h == 10) ? 24'hFF0000 : 24'h000000)) begin
                    failures++;
                    $display("FAIL bar_pixel h=%0d got=%h", e.h, {vga_r, vga_g, vga_b});
                end
            end
        end
    endtask

    task automatic test_gradient();
        exp_t e;
        logic seen_fs = 1'b0;
        mode = 2'd1;
        for (int i = 0; i < 2 * FR; i++) begin
            tick();
            e = sb.pop_front();
            if (e.fs) seen_fs = 1'b1;
            checks++;
            if ({vga_r, vga_g, vga_b} !== e.rgb) begin
                failures++;
                $display("FAIL gradient h=%0d v=%0d got=%h want=%h", e.h, e.v, {vga_r, vga_g, vga_b}, e.rgb);
            end
            if (seen_fs && e.h == 5 && e.v == 3) begin
                checks++;
                if ({vga_r, vga_g, vga_b} !== 24'h050308) begin
                    failures++;
                    $display("FAIL gradient_5_3 got=%h want=050308", {vga_r, vga_g, vga_b});
                end
            end
        end
    endtask

    task automatic test_mode_switch();
        exp_t e;
        int   phase = 0;   // 0: to origin, 1: to (7,4), 2: rest of frame, 3: grid frame
        int   grid_n = 0;
        mode = 2'd0;
        while (phase < 4) begin
            if (phase == 1 && m_h == 7 && m_v == 4) begin
                mode  = 2'd2;
                phase = 2;
            end
            tick();
            e = sb.pop_front();
            if (phase == 0 && m_h == 0 && m_v == 0) phase = 1;
            else if (phase == 2 && m_h == 0 && m_v == 0) phase = 3;
            checks++;
            if ({vga_r, vga_g, vga_b} !== e.rgb) begin
                failures++;
                $display("FAIL switch h=%0d v=%0d got=%h want=%h", e.h, e.v, {vga_r, vga_g, vga_b}, e.rgb);
            end
            if (phase == 2 && e.v == 5 && e.h == 2) begin
                checks++;
                if ({vga_r, vga_g, vga_b} !== 24'hFFFF00) begin
                    failures++;
                    $display("FAIL switch_keeps_bars got=%h want=FFFF00", {vga_r, vga_g, vga_b});
                end
            end
            if (phase == 3) begin
                if (e.v == 1 && (e.h == 0 || e.h == 4 || e.h == 8 || e.h == 12 || e.h == 15)) begin
                    checks++;
                    if ({vga_r, vga_g, vga_b} !== 24'hFFFFFF) begin
                        failures++;
                        $display("FAIL grid_line h=%0d got=%h want=FFFFFF", e.h, {vga_r, vga_g, vga_b});
                    end
                end
                if (e.v == 1 && e.h == 1) begin
                    checks++;
                    if ({vga_r, vga_g, vga_b} !== 24'h000000) begin
                        failures++;
                        $display("FAIL grid_gap got=%h want=000000", {vga_r, vga_g, vga_b});
                    end
                end
                grid_n++;
                if (grid_n == FR) phase = 4;
            end
        end
    endtask

    task automatic test_box();
        exp_t e;
        mode = 2'd3;
        for (int i = 0; i < 30 * FR; i++) begin
            tick();
            e = sb.pop_front();
            checks++;
            if ({de, hs, vs, frame_start, vga_r, vga_g, vga_b} !== {e.de, e.hs, e.vs, e.fs, e.rgb}) begin
                failures++;
                $display("FAIL box h=%0d v=%0d got=%h want=%h", e.h, e.v,
                         {de, hs, vs, frame_start, vga_r, vga_g, vga_b}, {e.de, e.hs, e.vs, e.fs, e.rgb});
            end
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        mode = 2'd3;
        while (!(m_h == 10 && m_v == 3)) begin
            tick();
            e = sb.pop_front();
            checks++;
            if ({vga_r, vga_g, vga_b} !== e.rgb) begin
                failures++;
                $display("FAIL pre_reset h=%0d v=%0d got=%h want=%h", e.h, e.v, {vga_r, vga_g, vga_b}, e.rgb);
            end
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({de, hs, vs, frame_start, vga_r, vga_g, vga_b} !== {4'b0110, 24'h0}) begin
            failures++;
            $display("FAIL async_reset got=%h want=%h",
                     {de, hs, vs, frame_start, vga_r, vga_g, vga_b}, {4'b0110, 24'h0});
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        tick();
        e = sb.pop_front();
        checks++;
        if (frame_start !== 1'b1) begin
            failures++;
            $display("FAIL restart_frame_start got=%b want=1", frame_start);
        end
        for (int i = 0; i < 3 * FR; i++) begin
            tick();
            e = sb.pop_front();
            checks++;
            if ({de, hs, vs, frame_start, vga_r, vga_g, vga_b} !== {e.de, e.hs, e.vs, e.fs, e.rgb}) begin
                failures++;
                $display("FAIL post_reset h=%0d v=%0d got=%h want=%h", e.h, e.v,
                         {de, hs, vs, frame_start, vga_r, vga_g, vga_b}, {e.de, e.hs, e.vs, e.fs, e.rgb});
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_timing();
        test_bars();
        test_gradient();
        test_mode_switch();
        test_box();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
